fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline register. It sits directly upstream of the load-use hazard unit. It consumes that unit's PC-write and IF/ID-write stall controls and supplies the IF/ID rs/rt fields the unit compares against. It also accepts a branch/jump redirect with flush and keeps saturating stall and flush event counters for debug.

---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/fetch_stage_if_id_reg.sv | 25 ++
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants and types for the instruction-fetch stage.
// Holds the NOP encoding, the rs/rt field positions and the IF/ID slot layout.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] PC_INCR   = 32'd4;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_EMPTY = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

  function automatic logic [4:0] rsField(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] rtField(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats write-enable, otherwise load or hold.
// A flushed slot carries a NOP with valid cleared so ID sees a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   write,
  input  if_id_t nextSlot,
  output if_id_t slot
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= IF_ID_EMPTY;
    end else if (flush) begin
      slot <= IF_ID_EMPTY;
    end else if (write) begin
      slot <= nextSlot;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem address, IF/ID register and
// saturating stall/flush event counters for debug.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             IF_ID_write,
  input  logic             redirect,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      IF_ID_instr,
  output logic [31:0]      IF_ID_pc4,
  output logic             IF_ID_valid,
  output logic [4:0]       IF_ID_rs,
  output logic [4:0]       IF_ID_rt,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0] pcReg;
  logic [31:0] pcPlus4;
  logic        pcStalled;
  if_id_t      fetched;
  if_id_t      slot;

  assign pcPlus4   = pcReg + PC_INCR;  // wraps modulo 2^32
  assign pcStalled = !redirect && !PCWrite;

  // Redirect wins over a hazard hold so a resolved branch is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcReg <= PC_RESET;
    end else if (redirect) begin
      pcReg <= redirect_target;
    end else if (PCWrite) begin
      pcReg <= pcPlus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pcStalled && stall_count != CNT_MAX) begin
        stall_count <= stall_count + 1'b1;
      end
      if (redirect && flush_count != CNT_MAX) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

  assign fetched = '{instr: imem_rdata, pc4: pcPlus4, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .write    (IF_ID_write),
    .nextSlot (fetched),
    .slot     (slot)
  );

  assign pc          = pcReg;
  assign imem_addr   = pcReg;
  assign IF_ID_instr = slot.instr;
  assign IF_ID_pc4   = slot.pc4;
  assign IF_ID_valid = slot.valid;
  assign IF_ID_rs    = rsField(slot.instr);
  assign IF_ID_rt    = rtField(slot.instr);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, saturation and
// async-reset sequences, then random traffic against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC  = 32'h0040_0000;
  localparam int          CW      = 4;
  localparam int          CNT_TOP = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          PCWrite, IF_ID_write, redirect;
  logic [31:0]   redirect_target, imem_rdata;
  logic [31:0]   imem_addr, pc, IF_ID_instr, IF_ID_pc4;
  logic          IF_ID_valid;
  logic [4:0]    IF_ID_rs, IF_ID_rt;
  logic [CW-1:0] stall_count, flush_count;

  int vectors    = 0;
  int miscompares = 0;

  // behavioural model state
  longint mPc, mPc4;
  logic [31:0] mInstr;
  logic mValid;
  int mStall, mFlush;

  fetch_stage #(.PC_RESET(RST_PC), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .PCWrite         (PCWrite),
    .IF_ID_write     (IF_ID_write),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .pc              (pc),
    .IF_ID_instr     (IF_ID_instr),
    .IF_ID_pc4       (IF_ID_pc4),
    .IF_ID_valid     (IF_ID_valid),
    .IF_ID_rs        (IF_ID_rs),
    .IF_ID_rt        (IF_ID_rt),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcw, ifw, rd;
    logic [31:0] tgt, rdata;
    logic [31:0] ePc, eInstr, ePc4;
    logic        eValid;
    int          eStall, eFlush;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmpAll(input string tag, input logic [31:0] ePc, input logic [31:0] eInstr,
                        input logic [31:0] ePc4, input logic eValid, input int eStall, input int eFlush);
    logic [31:0] ins;
    ins = eInstr;
    check({tag, " pc"}, pc, ePc);
    check({tag, " imem_addr"}, imem_addr, ePc);
    check({tag, " instr"}, IF_ID_instr, eInstr);
    check({tag, " pc4"}, IF_ID_pc4, ePc4);
    check({tag, " valid"}, 32'(IF_ID_valid), 32'(eValid));
    check({tag, " rs"}, 32'(IF_ID_rs), 32'(ins[25:21]));
    check({tag, " rt"}, 32'(IF_ID_rt), 32'(ins[20:16]));
    check({tag, " stall"}, 32'(stall_count), 32'(eStall));
    check({tag, " flush"}, 32'(flush_count), 32'(eFlush));
  endtask

  task automatic modelReset();
    mPc = RST_PC; mPc4 = 0; mInstr = 32'h0; mValid = 1'b0; mStall = 0; mFlush = 0;
  endtask

  // Drive one cycle's inputs, advance the model at the edge, return just after it.
  task automatic apply(input logic pcw, input logic ifw, input logic rd,
                       input logic [31:0] tgt, input logic [31:0] rdata);
    longint nextPc4;
    PCWrite = pcw; IF_ID_write = ifw; redirect = rd;
    redirect_target = tgt; imem_rdata = rdata;
    @(posedge clk);
    nextPc4 = (mPc + 4) % 64'h1_0000_0000;
    if (rd) begin
      mInstr = 32'h0; mPc4 = 0; mValid = 1'b0;
      mFlush = (mFlush + 1 > CNT_TOP) ? CNT_TOP : mFlush + 1;
    end else if (ifw) begin
      mInstr = rdata; mPc4 = nextPc4; mValid = 1'b1;
    end
    if (!rd && !pcw) mStall = (mStall + 1 > CNT_TOP) ? CNT_TOP : mStall + 1;
    if (rd) mPc = tgt;
    else if (pcw) mPc = nextPc4;
    #2;
  endtask

  function automatic vec_t mk(input logic pcw, ifw, rd, input logic [31:0] tgt, rdata,
                              input logic [31:0] ePc, eInstr, ePc4, input logic eValid,
                              input int eStall, eFlush);
    vec_t v;
    v.pcw = pcw; v.ifw = ifw; v.rd = rd; v.tgt = tgt; v.rdata = rdata;
    v.ePc = ePc; v.eInstr = eInstr; v.ePc4 = ePc4; v.eValid = eValid;
    v.eStall = eStall; v.eFlush = eFlush;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[12];
    vecs[0]  = mk(1,1,0, 0,            32'h3C01_0040, 32'h0040_0004, 32'h3C01_0040, 32'h0040_0004, 1, 0, 0);
    vecs[1]  = mk(1,1,0, 0,            32'h3421_0010, 32'h0040_0008, 32'h3421_0010, 32'h0040_0008, 1, 0, 0);
    vecs[2]  = mk(1,1,0, 0,            32'h8C22_0000, 32'h0040_000C, 32'h8C22_0000, 32'h0040_000C, 1, 0, 0);
    vecs[3]  = mk(0,0,0, 0,            32'h8C22_0000, 32'h0040_000C, 32'h8C22_0000, 32'h0040_000C, 1, 1, 0);
    vecs[4]  = mk(0,0,0, 0,            32'h8C22_0000, 32'h0040_000C, 32'h8C22_0000, 32'h0040_000C, 1, 2, 0);
    vecs[5]  = mk(0,0,1, 32'h0000_0100, 32'hAAAA_5555, 32'h0000_0100, 32'h0,         32'h0,         0, 2, 1);
    vecs[6]  = mk(1,1,0, 0,            32'h2008_0005, 32'h0000_0104, 32'h2008_0005, 32'h0000_0104, 1, 2, 1);
    vecs[7]  = mk(1,1,1, 32'hFFFF_FFFC, 32'h1111_1111, 32'hFFFF_FFFC, 32'h0,         32'h0,         0, 2, 2);
    vecs[8]  = mk(1,1,0, 0,            32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1, 2, 2);
    vecs[9]  = mk(1,0,0, 0,            32'h5555_AAAA, 32'h0000_0004, 32'h1234_5678, 32'h0000_0000, 1, 2, 2);
    vecs[10] = mk(0,1,0, 0,            32'hDEAD_BEEF, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0008, 1, 3, 2);
    vecs[11] = mk(0,1,1, 32'h0000_0203, 32'hCAFE_F00D, 32'h0000_0203, 32'h0,         32'h0,         0, 3, 3);

    reset = 1'b1; PCWrite = 0; IF_ID_write = 0; redirect = 0;
    redirect_target = 0; imem_rdata = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    cmpAll("reset", RST_PC, 32'h0, 32'h0, 1'b0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].pcw, vecs[i].ifw, vecs[i].rd, vecs[i].tgt, vecs[i].rdata);
      cmpAll($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eInstr, vecs[i].ePc4,
             vecs[i].eValid, vecs[i].eStall, vecs[i].eFlush);
    end

    // stall counter saturation
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, 0, $urandom);
      check($sformatf("sat%0d stall", i), 32'(stall_count), (3 + i + 1 > CNT_TOP) ? CNT_TOP : 3 + i + 1);
      check($sformatf("sat%0d pc", i), pc, 32'h0000_0203);
    end

    // async reset between edges while stalled
    #3 reset = 1'b1;
    #1 cmpAll("async_rst", RST_PC, 32'h0, 32'h0, 1'b0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    modelReset();
    cmpAll("rst_held", RST_PC, 32'h0, 32'h0, 1'b0, 0, 0);
    apply(1, 1, 0, 0, 32'h0BAD_F00D);
    cmpAll("restart", 32'h0040_0004, 32'h0BAD_F00D, 32'h0040_0004, 1'b1, 0, 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom, $urandom);
      cmpAll($sformatf("rnd%0d", i), mPc[31:0], mInstr, mPc4[31:0], mValid, mStall, mFlush);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
